rr_arbiter: RTL and testbench

- Parametrised N-channel request/grant arbiter with a registered one-hot grant. Successor to the fixed 3-channel priority grant FSM.
- Adds:
  - channel count parameter
  - runtime-selectable fixed-priority or round-robin policy
  - back-to-back handoff with no idle cycle
  - hold-limit preemption so one requester cannot starve the others
- Sits between N bus masters and a shared resource.

---
 rtl/rr_arbiter_if.sv | 36 +++
 rtl/rr_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N bus masters and the rr_arbiter.
//   req         : per-channel request level (master -> arbiter)
//   rr_mode     : 0 = fixed priority, 1 = round robin (master -> arbiter)
//   grant       : registered one-hot grant, zero when idle (arbiter -> master)
//   grant_id    : index of the current owner, 0 when idle (arbiter -> master)
//   grant_valid : high while any grant bit is set (arbiter -> master)
//   preempt     : one-cycle pulse on a forced hold-limit handoff (arbiter -> master)
interface rr_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) ();
    logic [N-1:0]   req;
    logic           rr_mode;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           preempt;

    modport master (
        output req,
        output rr_mode,
        input  grant,
        input  grant_id,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  req,
        input  rr_mode,
        output grant,
        output grant_id,
        output grant_valid,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter.sv
// N-channel request/grant arbiter with registered one-hot grant.
// Policy is selectable at runtime (fixed priority or round robin), a released
// grant is handed straight to the next requester without an idle cycle, and an
// optional hold limit forces a handoff so one owner cannot starve the others.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : rr_arbiter_if slave modport (req, rr_mode in; grant, grant_id,
//           grant_valid, preempt out)
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    parameter int IDW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_if.slave   bus
);

    // Hold counter only needs to reach MAX_HOLD; keep at least one bit.
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] MAX_HOLD_C = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE_C = HCW'(1'b1);

    logic [N-1:0]   grant_r;
    logic [IDW-1:0] grant_id_r;
    logic           grant_valid_r;
    logic           preempt_r;
    logic [IDW-1:0] last_r;
    logic [HCW-1:0] hold_cnt_r;

    logic [N-1:0]   grant_s;
    logic [IDW-1:0] grant_id_s;
    logic           grant_valid_s;
    logic           preempt_s;
    logic [IDW-1:0] last_s;
    logic [HCW-1:0] hold_cnt_s;
    logic [N-1:0]   others_s;
    logic           owner_req_s;
    logic           limit_hit_s;
    logic [N-1:0]   arb_vec_s;
    logic [IDW:0]   pick_s;

    // Returns {found, index}. Fixed mode scans from 0; round robin scans from
    // last+1 and wraps modulo N.
    function automatic logic [IDW:0] pick_f(
        input logic [N-1:0]   vec,
        input logic [IDW-1:0] last,
        input logic           rr
    );
        logic           found;
        logic [IDW-1:0] idx;
        int             start;
        int             cand;
        found = 1'b0;
        idx   = {IDW{1'b0}};
        start = rr ? (int'(last) + 1) : 0;
        for (int i = 0; i < N; i++) begin
            cand = ((start + i) >= N) ? (start + i - N) : (start + i);
            if (!found && vec[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Next-state: hold, forced handoff, release handoff, or idle arbitration.
    always_comb begin
        grant_s       = grant_r;
        grant_id_s    = grant_id_r;
        grant_valid_s = grant_valid_r;
        preempt_s     = 1'b0;
        last_s        = last_r;
        hold_cnt_s    = hold_cnt_r;
        others_s      = bus.req & ~grant_r;
        owner_req_s   = grant_valid_r && bus.req[grant_id_r];
        limit_hit_s   = (MAX_HOLD > 0) && grant_valid_r &&
                        (hold_cnt_r == MAX_HOLD_C) && (others_s != {N{1'b0}});
        // On release or idle the owner bit of req is already low, so masking it
        // gives the same vector in every arbitration case.
        arb_vec_s     = others_s;
        pick_s        = pick_f(arb_vec_s, last_r, bus.rr_mode);

        if (owner_req_s && !limit_hit_s) begin
            if (hold_cnt_r < MAX_HOLD_C) begin
                hold_cnt_s = hold_cnt_r + HOLD_ONE_C;
            end else begin
                hold_cnt_s = hold_cnt_r;
            end
        end else if (pick_s[IDW]) begin
            grant_s                   = {N{1'b0}};
            grant_s[pick_s[IDW-1:0]]  = 1'b1;
            grant_id_s                = pick_s[IDW-1:0];
            grant_valid_s             = 1'b1;
            last_s                    = pick_s[IDW-1:0];
            hold_cnt_s                = HOLD_ONE_C;
            // A still-requesting owner only loses the grant through the limit.
            preempt_s                 = owner_req_s;
        end else begin
            grant_s       = {N{1'b0}};
            grant_id_s    = {IDW{1'b0}};
            grant_valid_s = 1'b0;
            hold_cnt_s    = {HCW{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r       <= {N{1'b0}};
            grant_id_r    <= {IDW{1'b0}};
            grant_valid_r <= 1'b0;
            preempt_r     <= 1'b0;
            last_r        <= IDW'(N - 1);
            hold_cnt_r    <= {HCW{1'b0}};
        end else begin
            grant_r       <= grant_s;
            grant_id_r    <= grant_id_s;
            grant_valid_r <= grant_valid_s;
            preempt_r     <= preempt_s;
            last_r        <= last_s;
            hold_cnt_r    <= hold_cnt_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.preempt     = preempt_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter. Three builds share one clock:
//   a: N=4, MAX_HOLD=0   b: N=4, MAX_HOLD=4   c: N=8, MAX_HOLD=0
module tb_rr_arbiter;

    logic clk;
    logic reset_a;
    logic reset_b;
    logic reset_c;
    int   tests_run;
    int   tests_failed;

    rr_arbiter_if #(.N(4)) bus_a ();
    rr_arbiter_if #(.N(4)) bus_b ();
    rr_arbiter_if #(.N(8)) bus_c ();

    rr_arbiter #(.N(4), .MAX_HOLD(0)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
    rr_arbiter #(.N(4), .MAX_HOLD(4)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));
    rr_arbiter #(.N(8), .MAX_HOLD(0)) dut_c (.clk(clk), .reset(reset_c), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        bus_a.req = 4'b1111;
        bus_a.rr_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus_a.grant !== 4'b0000 || bus_a.grant_valid !== 1'b0 ||
                bus_a.preempt !== 1'b0 || bus_a.grant_id !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: grant=%b valid=%b preempt=%b id=%0d expected 0000/0/0/0",
                         i, bus_a.grant, bus_a.grant_valid, bus_a.preempt, bus_a.grant_id);
            end
        end
        reset_a = 1'b0;
        step();
        tests_run++;
        if (bus_a.grant !== 4'b0001 || bus_a.grant_id !== 2'd0 || bus_a.grant_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_grant: grant=%b id=%0d valid=%b expected 0001/0/1",
                     bus_a.grant, bus_a.grant_id, bus_a.grant_valid);
        end
        bus_a.req = 4'b0000;
        step();
        tests_run++;
        if (bus_a.grant !== 4'b0000 || bus_a.grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: grant=%b valid=%b expected 0000/0", bus_a.grant, bus_a.grant_valid);
        end
    endtask

    task automatic test_fixed_handoff();
        logic [3:0] req_v [4];
        logic [3:0] exp_g [4];
        logic [1:0] exp_id [4];
        req_v = '{4'b0110, 4'b0110, 4'b0100, 4'b0000};
        exp_g = '{4'b0010, 4'b0010, 4'b0100, 4'b0000};
        exp_id = '{2'd1, 2'd1, 2'd2, 2'd0};
        bus_a.rr_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_a.req = req_v[i];
            step();
            tests_run++;
            if (bus_a.grant !== exp_g[i] || bus_a.grant_id !== exp_id[i] ||
                bus_a.grant_valid !== (exp_g[i] != 4'b0000) || bus_a.preempt !== 1'b0) begin
                tests_failed++;
                $display("FAIL fixed_handoff[%0d]: grant=%b id=%0d valid=%b preempt=%b expected %b/%0d",
                         i, bus_a.grant, bus_a.grant_id, bus_a.grant_valid, bus_a.preempt, exp_g[i], exp_id[i]);
            end
        end
    endtask

    task automatic reset_b_cycle();
        bus_b.req = 4'b0000;
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
    endtask

    task automatic test_rr_preempt();
        logic [3:0] exp_g;
        logic       exp_p;
        reset_b_cycle();
        bus_b.rr_mode = 1'b1;
        bus_b.req = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            step();
            exp_g = 4'b0001 << ((i / 4) % 4);
            exp_p = (i > 0) && ((i % 4) == 0);
            tests_run++;
            if (bus_b.grant !== exp_g || bus_b.preempt !== exp_p ||
                bus_b.grant_id !== 2'((i / 4) % 4)) begin
                tests_failed++;
                $display("FAIL rr_preempt[%0d]: grant=%b preempt=%b id=%0d expected %b/%b/%0d",
                         i, bus_b.grant, bus_b.preempt, bus_b.grant_id, exp_g, exp_p, (i / 4) % 4);
            end
        end
    endtask

    task automatic test_fixed_limit();
        logic [3:0] exp_g;
        logic       exp_p;
        reset_b_cycle();
        bus_b.rr_mode = 1'b0;
        bus_b.req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_g = 4'b0001 << ((i / 4) % 2);
            exp_p = (i > 0) && ((i % 4) == 0);
            tests_run++;
            if (bus_b.grant !== exp_g || bus_b.preempt !== exp_p) begin
                tests_failed++;
                $display("FAIL fixed_limit[%0d]: grant=%b preempt=%b expected %b/%b",
                         i, bus_b.grant, bus_b.preempt, exp_g, exp_p);
            end
        end
    endtask

    task automatic test_lone_requester();
        reset_b_cycle();
        bus_b.rr_mode = 1'b0;
        bus_b.req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if (bus_b.grant !== 4'b0001 || bus_b.preempt !== 1'b0) begin
                tests_failed++;
                $display("FAIL lone[%0d]: grant=%b preempt=%b expected 0001/0", i, bus_b.grant, bus_b.preempt);
            end
        end
        bus_b.req = 4'b1001;
        step();
        tests_run++;
        if (bus_b.grant !== 4'b1000 || bus_b.preempt !== 1'b1 || bus_b.grant_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL lone_second_req: grant=%b preempt=%b id=%0d expected 1000/1/3",
                     bus_b.grant, bus_b.preempt, bus_b.grant_id);
        end
        // Owner 3 now holds for cycles 2..4 of its tenure.
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus_b.grant !== 4'b1000 || bus_b.preempt !== 1'b0) begin
                tests_failed++;
                $display("FAIL lone_hold[%0d]: grant=%b preempt=%b expected 1000/0", i, bus_b.grant, bus_b.preempt);
            end
        end
    endtask

    // Owner drops req exactly when the limit would fire: plain release.
    task automatic test_release_at_limit();
        bus_b.req = 4'b0001;
        step();
        tests_run++;
        if (bus_b.grant !== 4'b0001 || bus_b.preempt !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_at_limit: grant=%b preempt=%b expected 0001/0", bus_b.grant, bus_b.preempt);
        end
    endtask

    task automatic test_reset_mid_grant();
        bus_c.rr_mode = 1'b0;
        bus_c.req = 8'h00;
        reset_c = 1'b1;
        step();
        reset_c = 1'b0;
        bus_c.req = 8'h10;
        step();
        tests_run++;
        if (bus_c.grant !== 8'h10 || bus_c.grant_id !== 3'd4) begin
            tests_failed++;
            $display("FAIL mid_grant_setup: grant=%h id=%0d expected 10/4", bus_c.grant, bus_c.grant_id);
        end
        bus_c.req = 8'h32;
        reset_c = 1'b1;
        step();
        tests_run++;
        if (bus_c.grant !== 8'h00 || bus_c.grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_grant_reset: grant=%h valid=%b expected 00/0", bus_c.grant, bus_c.grant_valid);
        end
        reset_c = 1'b0;
        bus_c.rr_mode = 1'b1;
        step();
        tests_run++;
        if (bus_c.grant !== 8'h02 || bus_c.grant_id !== 3'd1) begin
            tests_failed++;
            $display("FAIL mid_grant_rr_restart: grant=%h id=%0d expected 02/1", bus_c.grant, bus_c.grant_id);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;
        bus_a.req = 4'b0000;
        bus_a.rr_mode = 1'b0;
        bus_b.req = 4'b0000;
        bus_b.rr_mode = 1'b0;
        bus_c.req = 8'h00;
        bus_c.rr_mode = 1'b0;
        step();
        test_reset();
        test_fixed_handoff();
        test_rr_preempt();
        test_fixed_limit();
        test_lone_requester();
        test_release_at_limit();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
